// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter feeding the frame-buffer image memory, plus the transition-phase counter.
// Optional macro FBW_SRC0_PRIORITY_EN: source 0 (clock overlay) always wins arbitration when it requests.
module fb_write_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 20,
  parameter int NUM_PHASES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      phase_tick,
  input  logic                      frame_tick,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_gnt,
  output logic [2:0]                phase,
  output logic [ADDR_W-1:0]         IM_A,
  output logic [DATA_W-1:0]         IM_D,
  output logic                      IM_WEN,
  output logic                      busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [2:0] PH_MAX = 3'(NUM_PHASES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [NUM_SRC-1:0] cand_req;
  logic               accept;
  int                 idx;

  // Winner search starting at the round-robin pointer; source 0 may bypass it.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_req   = src_req;
    idx        = 0;
`ifdef FBW_SRC0_PRIORITY_EN
    cand_req[0] = 1'b0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!pick_valid && cand_req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
`ifdef FBW_SRC0_PRIORITY_EN
    if (src_req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  assign accept = (state == GRANT) && src_req[gnt_idx];

  // Burst FSM with registered grant and registered memory-write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      src_gnt <= '0;
      busy    <= 1'b0;
      IM_A    <= '0;
      IM_D    <= '0;
      IM_WEN  <= 1'b1;
    end else begin
      IM_WEN <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= GRANT;
            gnt_idx <= pick_idx;
            src_gnt <= NUM_SRC'(1) << pick_idx;
            busy    <= 1'b1;
          end
        end
        GRANT: begin
          if (accept) begin
            IM_A   <= src_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            IM_D   <= src_data[int'(gnt_idx)*DATA_W +: DATA_W];
            IM_WEN <= 1'b0;
            if (src_last[gnt_idx]) begin
              state   <= IDLE;
              src_gnt <= '0;
              busy    <= 1'b0;
`ifdef FBW_SRC0_PRIORITY_EN
              // Overlay bursts do not disturb the rotation among the other sources.
              if (gnt_idx != '0) begin
                if (int'(gnt_idx) == NUM_SRC - 1) rr_ptr <= '0;
                else rr_ptr <= gnt_idx + 1'b1;
              end
`else
              if (int'(gnt_idx) == NUM_SRC - 1) rr_ptr <= '0;
              else rr_ptr <= gnt_idx + 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transition phase: a coincident frame_tick clears first, then phase_tick advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (frame_tick && phase_tick) begin
      phase <= 3'd1;
    end else if (frame_tick) begin
      phase <= '0;
    end else if (phase_tick && phase != PH_MAX) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of write sources; legal 2..8.
REQ-002 Parameter DATA_W, default 24, pixel width in bits.
REQ-003 Parameter ADDR_W, default 20, image-memory address width.
REQ-004 Parameter NUM_PHASES, default 2, transition phases per frame period; legal 2..8.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 phase_tick  input  1  single-cycle pulse; advances transition phase (0.2 s tick).
REQ-008 frame_tick  input  1  single-cycle pulse; starts new frame period (2 s tick).
REQ-009 src_req  input  NUM_SRC  per-source write request, held until granted burst ends.
REQ-010 src_addr  input  NUM_SRC*ADDR_W  per-source address, slice i = source i.
REQ-011 src_data  input  NUM_SRC*DATA_W  per-source pixel, slice i = source i.
REQ-012 src_last  input  NUM_SRC  marks final beat of source burst.
REQ-013 src_gnt  output  NUM_SRC  one-hot grant; beat accepted when src_gnt[i] and src_req[i] both high.
REQ-014 phase  output  3  current transition phase, 0..NUM_PHASES-1.
REQ-015 IM_A  output  ADDR_W  image-memory address.
REQ-016 IM_D  output  DATA_W  image-memory write data.
REQ-017 IM_WEN  output  1  active-low write enable.
REQ-018 busy  output  1  high while FSM in GRANT.

Function
REQ-019 FSM states IDLE, GRANT; IDLE->GRANT when any src_req high, GRANT->IDLE after accepted beat with src_last high.
REQ-020 Arbitration in IDLE only; grant held for whole burst, no preemption.
REQ-021 Round-robin: search starts at (last granted index + 1) mod NUM_SRC; after reset, search starts at 0.
REQ-022 src_gnt asserts the cycle after IDLE detects a request; zero while IDLE.
REQ-023 Accepted beat registered: IM_A/IM_D/IM_WEN=0 appear exactly one cycle after acceptance.
REQ-024 Cycle with grant but src_req low: no beat, IM_WEN=1, IM_A/IM_D hold previous values, grant kept.
REQ-025 Back-to-back bursts: GRANT->IDLE->GRANT, minimum one idle cycle between bursts.
REQ-026 phase increments on phase_tick, saturates at NUM_PHASES-1; frame_tick clears to 0.
REQ-027 phase_tick and frame_tick in same cycle: phase becomes 1 (clear, then advance).
REQ-028 phase changes take effect the cycle after the tick; ticks never affect FSM or grants.
REQ-029 Source index >= NUM_SRC never granted; unused slices ignored.

Reset
REQ-030 reset asserted, any state: FSM=IDLE, src_gnt=0, IM_WEN=1, IM_A=0, IM_D=0, phase=0, busy=0, round-robin pointer=0.
REQ-031 Reset mid-burst aborts burst; no further write issued; source must re-request.

Configuration
REQ-032 Macro FBW_SRC0_PRIORITY_EN defined: source 0 (clock overlay) wins any IDLE arbitration it requests, others round-robin among themselves; undefined: pure round-robin per REQ-021.

Verification
REQ-033 Reset mid-burst (src1 granted, 3 beats done) -> next cycle IM_WEN=1, src_gnt=0, phase=0.
REQ-034 src0..src3 request together, 2-beat bursts, macro undefined -> grant order 0,1,2,3; 8 writes, IM_WEN low 8 cycles total.
REQ-035 src1 burst addr 0x00010..0x00012, data 0xA5A5A5.. -> IM_A/IM_D match one cycle after each acceptance; src_req low mid-burst -> IM_WEN=1 that cycle.
REQ-036 NUM_PHASES=4: three phase_tick then one more -> phase 1,2,3,3; frame_tick -> 0; both same cycle -> 1.
REQ-037 Macro defined, src2 in burst, src0 and src3 request -> after src2 last beat src0 granted, then src3.
REQ-038 NUM_SRC=8, DATA_W=16, ADDR_W=18: src7 single-beat write 0x3FFFF/0xFFFF -> IM_A=0x3FFFF, IM_D=0xFFFF, pointer wraps to 0.
